// File: rtl/usb3_frame_tx.sv
// Slave-FIFO write engine: streams a readback frame from a 1-cycle-latency bank
// over the 32-bit USB3 FIFO bus, honouring FLAGB and closing with a trailer+PKTEND.
module usb3_frame_tx #(
  parameter int          FRAME_WORDS = 256,
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] TRAILER     = 32'hFF00AAAA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              USB3_FLAGB,
  output logic [31:0]       USB3_DQ,
  output logic              USB3_SLWR_n,
  output logic              USB3_PKTEND_n,
  output logic              dq_oe,
  output logic [3:0]        usb_wr_state,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(FRAME_WORDS - 2);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_FLAG = 4'd1,
    S_PREFETCH  = 4'd2,
    S_WRITE     = 4'd3,
    S_PAUSE     = 4'd4,
    S_TRAILER   = 4'd5,
    S_DONE      = 4'd6
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_word_idx;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [31:0]       r_dq;
  logic              r_slwr_n;
  logic              r_pktend_n;
  logic              r_dq_oe;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_word_idx   <= '0;
      r_rd_addr    <= '0;
      r_dq         <= '0;
      r_slwr_n     <= 1'b1;
      r_pktend_n   <= 1'b1;
      r_dq_oe      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      // One request can be queued while a frame is in flight, DONE included.
      if (frame_req && r_state != S_IDLE) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_slwr_n     <= 1'b1;
          r_pktend_n   <= 1'b1;
          r_frame_done <= 1'b0;
          if (frame_req || r_pending) begin
            r_word_idx <= '0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b1;
            r_pending  <= 1'b0;
            r_dq_oe    <= 1'b1;
            r_state    <= S_WAIT_FLAG;
          end
        end
        S_WAIT_FLAG, S_PAUSE: begin
          r_slwr_n  <= 1'b1;
          r_rd_addr <= ADDR_W'(r_word_idx);
          if (USB3_FLAGB) r_state <= S_PREFETCH;
        end
        S_PREFETCH: begin
          r_slwr_n  <= 1'b1;
          r_rd_addr <= ADDR_W'(r_word_idx + IDX_W'(1));
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          if (USB3_FLAGB) begin
            r_dq       <= rd_data;
            r_slwr_n   <= 1'b0;
            r_word_idx <= r_word_idx + IDX_W'(1);
            r_rd_addr  <= ADDR_W'(r_word_idx + IDX_W'(2));
            if (r_word_idx == LAST_DATA) r_state <= S_TRAILER;
          end else begin
            // Word at r_word_idx was not written; re-fetch it after the pause.
            r_slwr_n  <= 1'b1;
            r_rd_addr <= ADDR_W'(r_word_idx);
            r_state   <= S_PAUSE;
          end
        end
        S_TRAILER: begin
          if (USB3_FLAGB) begin
            r_dq         <= TRAILER;
            r_slwr_n     <= 1'b0;
            r_pktend_n   <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_slwr_n <= 1'b1;
          end
        end
        S_DONE: begin
          r_slwr_n     <= 1'b1;
          r_pktend_n   <= 1'b1;
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_dq_oe      <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_addr       = r_rd_addr;
  assign USB3_DQ       = r_dq;
  assign USB3_SLWR_n   = r_slwr_n;
  assign USB3_PKTEND_n = r_pktend_n;
  assign dq_oe         = r_dq_oe;
  assign usb_wr_state  = r_state;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_usb3_frame_tx.sv
// Bench for usb3_frame_tx: bank model, bus monitor, frame-level reference built
// from bank contents + trailer, directed and randomized FLAGB scenarios.
module tb_usb3_frame_tx;
  localparam int          FW  = 256;
  localparam int          AW  = 8;
  localparam logic [31:0] TRL = 32'hFF00AAAA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_req = 1'b0;
  logic          flagb = 1'b1;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data = '0;
  logic [31:0]   dq;
  logic          slwr_n, pktend_n, dq_oe, busy, frame_done;
  logic [3:0]    st;
  logic [31:0]   bank [FW];

  usb3_frame_tx #(.FRAME_WORDS(FW), .ADDR_W(AW), .TRAILER(TRL)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .USB3_FLAGB(flagb), .USB3_DQ(dq), .USB3_SLWR_n(slwr_n),
    .USB3_PKTEND_n(pktend_n), .dq_oe(dq_oe), .usb_wr_state(st), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic prev_flagb = 1'b1;
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_flagb <= flagb;
    rd_data    <= bank[rd_addr];
  end

  // Bus monitor
  logic [31:0] got_q [$];
  int start_q [$];
  int done_q [$];
  int pkt_cnt = 0, bad_pkt = 0, viol = 0, run = 0, max_run = 0;
  bit in_frame = 0;

  always @(negedge clk) begin
    if (slwr_n === 1'b0) begin
      if (!in_frame) begin start_q.push_back(cyc); in_frame = 1; end
      got_q.push_back(dq);
      run++;
      if (run > max_run) max_run = run;
      if (prev_flagb !== 1'b1) viol++;
    end else run = 0;
    if (pktend_n === 1'b0) begin
      pkt_cnt++;
      in_frame = 0;
      if (slwr_n !== 1'b0 || dq !== TRL) bad_pkt++;
    end
    if (frame_done === 1'b1) done_q.push_back(cyc);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    got_q.delete(); start_q.delete(); done_q.delete();
    pkt_cnt = 0; bad_pkt = 0; viol = 0; run = 0; max_run = 0; in_frame = 0;
  endtask

  task automatic fill_rand();
    foreach (bank[i]) bank[i] = $urandom;
  endtask

  task automatic pulse_req(output int e);
    frame_req = 1'b1;
    tick();
    e = cyc;
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_q.size() < target && n < budget) begin tick(); n++; end
    chk({tag, "_timeout"}, int'(done_q.size() >= target), 1);
  endtask

  task automatic wait_words(input string tag, input int target, input int budget);
    int n = 0;
    while (got_q.size() < target && n < budget) begin tick(); n++; end
    chk({tag, "_timeout"}, int'(got_q.size() >= target), 1);
  endtask

  // Expected frame: bank words 0..FW-2 then the trailer.
  task automatic chk_frame(input string tag, input int base);
    int bad = 0;
    logic [31:0] exp;
    for (int i = 0; i < FW; i++) begin
      exp = (i == FW-1) ? TRL : bank[i];
      if (base + i >= got_q.size()) bad++;
      else if (got_q[base+i] !== exp) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_common(input string tag, input int frames);
    chk({tag, "_count"}, got_q.size(), frames * FW);
    chk({tag, "_pkt"}, pkt_cnt, frames);
    chk({tag, "_badpkt"}, bad_pkt, 0);
    chk({tag, "_flagviol"}, viol, 0);
    chk({tag, "_done"}, done_q.size(), frames);
  endtask

  localparam logic [48:0] RST_VEC = {8'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};

  initial begin
    int e, sz0, n;
    foreach (bank[i]) bank[i] = 32'(i);
    rst_n = 1'b0;
    tick(3);
    chkv("reset", 64'({rd_addr, dq, slwr_n, pktend_n, dq_oe, st, busy, frame_done}), 64'(RST_VEC));
    rst_n = 1'b1;
    tick(2);

    // 1: bank[i]=i, no stalls
    clr();
    pulse_req(e);
    wait_done("t1", 1, 400);
    tick(3);
    chk_common("t1", 1);
    chk_frame("t1_data", 0);
    chk("t1_first", (start_q.size() > 0) ? start_q[0] : -1, e + 3);
    chk("t1_run", max_run, FW);
    chkv("t1_w100", 64'((got_q.size() > 100) ? got_q[100] : 32'hDEAD), 64'(32'd100));
    chkv("t1_idle", 64'({st, busy, dq_oe}), 64'h0);

    // 2: five-cycle stall mid-frame
    fill_rand(); clr();
    pulse_req(e);
    wait_words("t2_w101", 101, 400);
    flagb = 1'b0;
    tick();
    sz0 = got_q.size();
    tick(4);
    chk("t2_stall", got_q.size(), sz0);
    flagb = 1'b1;
    wait_done("t2", 1, 400);
    tick(3);
    chk_common("t2", 1);
    chk_frame("t2_data", 0);

    // 3: FLAGB low at request for 20 cycles, then random FLAGB
    fill_rand(); clr();
    flagb = 1'b0;
    pulse_req(e);
    tick(19);
    chkv("t3_wait", 64'({st, dq_oe, busy}), 64'({4'd1, 1'b1, 1'b1}));
    chk("t3_nostrobe", got_q.size(), 0);
    n = 0;
    while (done_q.size() < 1 && n < 3000) begin
      flagb = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("t3_timeout", int'(done_q.size() >= 1), 1);
    flagb = 1'b1;
    tick(3);
    chk_common("t3", 1);
    chk_frame("t3_data", 0);

    // 4: FLAGB low on the trailer cycle
    fill_rand(); clr();
    pulse_req(e);
    wait_words("t4_w254", 254, 400);
    flagb = 1'b0;
    tick(6);
    chkv("t4_hold", 64'({st, slwr_n, pktend_n}), 64'({4'd5, 1'b1, 1'b1}));
    chk("t4_words", got_q.size(), FW - 1);
    chk("t4_nopkt", pkt_cnt, 0);
    flagb = 1'b1;
    wait_done("t4", 1, 50);
    tick(3);
    chk_common("t4", 1);
    chk_frame("t4_data", 0);

    // 5: three requests during a frame -> exactly one queued frame
    fill_rand(); clr();
    pulse_req(e);
    tick(10); pulse_req(n);
    tick(40); pulse_req(n);
    tick(100); pulse_req(n);
    wait_done("t5", 2, 1200);
    tick(30);
    chk_common("t5", 2);
    chk_frame("t5_data0", 0);
    chk_frame("t5_data1", FW);
    chk("t5_restart", (start_q.size() > 1 && done_q.size() > 0) ? start_q[1] - done_q[0] : -1, 5);
    chkv("t5_idle", 64'({st, busy}), 64'h0);

    // 6: reset mid-frame with a queued request
    fill_rand(); clr();
    pulse_req(e);
    wait_words("t6_w21", 21, 400);
    pulse_req(n);
    wait_words("t6_w51", 51, 400);
    rst_n = 1'b0;
    tick();
    chkv("t6_reset", 64'({rd_addr, dq, slwr_n, pktend_n, dq_oe, st, busy, frame_done}), 64'(RST_VEC));
    rst_n = 1'b1;
    tick(10);
    chk("t6_nopkt", pkt_cnt, 0);
    chk("t6_nodone", done_q.size(), 0);
    chkv("t6_idle", 64'({st, busy}), 64'h0);
    clr();
    pulse_req(e);
    wait_done("t6", 1, 400);
    tick(3);
    chk_common("t6", 1);
    chk_frame("t6_data", 0);
    chk("t6_first", (start_q.size() > 0) ? start_q[0] : -1, e + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
